// File: rtl/voice_allocator_if.sv
// Command and voice-output bundle between the CPU parameter block and the voice allocator.
// The master drives note commands; the slave returns per-voice increments, enables and status.
interface voice_allocator_if #(
    parameter int NUM_VOICES = 4,
    parameter int FREQ_BITS  = 32,
    parameter int NOTE_BITS  = 7
);
    logic                            cmd_valid;
    logic                            cmd_ready;
    logic                            cmd_on;
    logic [NOTE_BITS-1:0]            cmd_note;
    logic [FREQ_BITS-1:0]            cmd_freq;
    logic [NUM_VOICES*FREQ_BITS-1:0] freq_out;
    logic [NUM_VOICES-1:0]           gate;
    logic                            any_gate;
    logic                            steal;
    logic [1:0]                      voice_sel;

    modport master (
        output cmd_valid, cmd_on, cmd_note, cmd_freq,
        input  cmd_ready, freq_out, gate, any_gate, steal, voice_sel
    );

    modport slave (
        input  cmd_valid, cmd_on, cmd_note, cmd_freq,
        output cmd_ready, freq_out, gate, any_gate, steal, voice_sel
    );
endinterface

// File: rtl/voice_allocator.sv
// Four-slot polyphonic voice scheduler: retrigger, then first free slot, then steal the oldest voice.
// Each command is scanned one voice per cycle and committed in a single cycle.
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int FREQ_BITS  = 32,
    parameter int NOTE_BITS  = 7,
    parameter int AGE_BITS   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              panic,
    voice_allocator_if.slave  bus
);
    localparam logic [1:0] LAST_IDX = 2'(NUM_VOICES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_COMMIT
    } state_t;

    state_t                r_state;
    logic [1:0]            r_idx;

    logic                  r_cmd_on;
    logic [NOTE_BITS-1:0]  r_cmd_note;
    logic [FREQ_BITS-1:0]  r_cmd_freq;

    logic                  r_match_found;
    logic [1:0]            r_match_idx;
    logic                  r_free_found;
    logic [1:0]            r_free_idx;
    logic [1:0]            r_oldest_idx;
    logic [AGE_BITS-1:0]   r_oldest_age;

    logic [NOTE_BITS-1:0]  r_note [NUM_VOICES];
    logic [FREQ_BITS-1:0]  r_freq [NUM_VOICES];
    logic [AGE_BITS-1:0]   r_age  [NUM_VOICES];
    logic [NUM_VOICES-1:0] r_gate;
    logic                  r_steal;
    logic [1:0]            r_voice_sel;

    logic [1:0]            w_alloc_idx;

    assign w_alloc_idx = r_free_found ? r_free_idx : r_oldest_idx;

    // NOTE: every register here uses non-blocking assignment so all trackers see the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            r_cmd_on      <= 1'b0;
            r_cmd_note    <= '0;
            r_cmd_freq    <= '0;
            r_match_found <= 1'b0;
            r_match_idx   <= '0;
            r_free_found  <= 1'b0;
            r_free_idx    <= '0;
            r_oldest_idx  <= '0;
            r_oldest_age  <= '0;
            r_gate        <= '0;
            r_steal       <= 1'b0;
            r_voice_sel   <= '0;
            // NOTE: the per-voice arrays are small register files, so they are cleared explicitly on reset.
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_note[v] <= '0;
                r_freq[v] <= '0;
                r_age[v]  <= '0;
            end
        end else if (panic) begin
            r_state <= ST_IDLE;
            r_gate  <= '0;
            r_steal <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_age[v] <= '0;
            end
        end else begin
            r_steal <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_cmd_on      <= bus.cmd_on;
                        r_cmd_note    <= bus.cmd_note;
                        r_cmd_freq    <= bus.cmd_freq;
                        r_match_found <= 1'b0;
                        r_match_idx   <= '0;
                        r_free_found  <= 1'b0;
                        r_free_idx    <= '0;
                        r_oldest_idx  <= '0;
                        r_oldest_age  <= '0;
                        r_idx         <= '0;
                        r_state       <= ST_SCAN;
                    end
                end

                ST_SCAN: begin
                    if (!r_match_found && r_gate[r_idx] && (r_note[r_idx] == r_cmd_note)) begin
                        r_match_found <= 1'b1;
                        r_match_idx   <= r_idx;
                    end
                    if (!r_free_found && !r_gate[r_idx]) begin
                        r_free_found <= 1'b1;
                        r_free_idx   <= r_idx;
                    end
                    // Strict compare keeps the lowest index on an age tie.
                    if (r_age[r_idx] > r_oldest_age) begin
                        r_oldest_idx <= r_idx;
                        r_oldest_age <= r_age[r_idx];
                    end
                    r_idx <= r_idx + 2'd1;
                    if (r_idx == LAST_IDX) begin
                        r_state <= ST_COMMIT;
                    end
                end

                ST_COMMIT: begin
                    r_state <= ST_IDLE;
                    if (r_cmd_on) begin
                        if (r_match_found) begin
                            r_freq[r_match_idx] <= r_cmd_freq;
                            r_age[r_match_idx]  <= '0;
                            r_voice_sel         <= r_match_idx;
                        end else begin
                            for (int v = 0; v < NUM_VOICES; v++) begin
                                if (2'(v) == w_alloc_idx) begin
                                    r_note[v] <= r_cmd_note;
                                    r_freq[v] <= r_cmd_freq;
                                    r_gate[v] <= 1'b1;
                                    r_age[v]  <= '0;
                                end else if (r_gate[v] && (r_age[v] != '1)) begin
                                    r_age[v] <= r_age[v] + AGE_BITS'(1);
                                end
                            end
                            r_steal     <= !r_free_found;
                            r_voice_sel <= w_alloc_idx;
                        end
                    end else if (r_match_found) begin
                        r_gate[r_match_idx] <= 1'b0;
                        r_voice_sel         <= r_match_idx;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the output flattening assigns a default first so no latch can be inferred.
    always_comb begin
        bus.freq_out = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            bus.freq_out[v*FREQ_BITS +: FREQ_BITS] = r_freq[v];
        end
    end

    assign bus.cmd_ready = (r_state == ST_IDLE);
    assign bus.gate      = r_gate;
    assign bus.any_gate  = |r_gate;
    assign bus.steal     = r_steal;
    assign bus.voice_sel = r_voice_sel;
endmodule
